// File: rtl/free_list_ckpt.sv
// Speculative free list of physical register tags for rename: circular queue with
// all-or-nothing allocation, per-branch head checkpoints and flush to the architectural head.
module free_list_ckpt #(
   parameter int PREG_W   = 7,
   parameter int NUM_PREG = 80,
   parameter int NUM_AREG = 32,
   parameter int ALLOC_W  = 4,
   parameter int RLS_W    = 8,
   parameter int NCKPT    = 8,
   localparam int DEPTH   = NUM_PREG - NUM_AREG,
   localparam int CK_W    = $clog2(NCKPT),
   localparam int PTR_W   = $clog2(2 * DEPTH),
   localparam int CNT_W   = $clog2(DEPTH + 1),
   localparam int CMT_W   = $clog2(ALLOC_W * 2 + 1)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [ALLOC_W-1:0]        alloc_req_i,
   input  logic                      stall_i,
   output logic                      alloc_gnt_o,
   output logic [ALLOC_W*PREG_W-1:0] alloc_preg_o,
   output logic                      alloc_stall_o,
   input  logic [RLS_W-1:0]          rls_vld_i,
   input  logic [RLS_W*PREG_W-1:0]   rls_preg_i,
   input  logic [CMT_W-1:0]          commit_cnt_i,
   input  logic                      ckpt_we_i,
   input  logic [CK_W-1:0]           ckpt_id_i,
   input  logic                      rec_i,
   input  logic [CK_W-1:0]           rec_id_i,
   input  logic                      flush_i,
   output logic [CNT_W-1:0]          free_cnt_o,
   output logic                      err_ovf_o
);

   localparam int               IDX_W   = $clog2(DEPTH);
   localparam logic [PTR_W:0]   TWO_D   = (PTR_W + 1)'(2 * DEPTH);
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

   typedef logic [PTR_W-1:0] ptr_t;

   // Pointers carry a phase bit by living in [0, 2*DEPTH); full and empty stay distinct.
   function automatic ptr_t ptr_add(input ptr_t p, input ptr_t inc);
      logic [PTR_W:0] s;
      s = {1'b0, p} + {1'b0, inc};
      if (s >= TWO_D) s = s - TWO_D;
      return ptr_t'(s);
   endfunction

   function automatic logic [IDX_W-1:0] ptr_idx(input ptr_t p);
      return (p >= DEPTH_P) ? IDX_W'(p - DEPTH_P) : IDX_W'(p);
   endfunction

   logic [PREG_W-1:0] fl_mem [DEPTH];
   ptr_t              ckpt   [NCKPT];
   ptr_t              head, tail, arch_head;
   logic              err_ovf;

   ptr_t              occ, room, n_req, n_rls, head_gnt, head_nxt, cmt;
   logic              gnt, rls_ovf;
   logic [RLS_W-1:0]  rls_we;
   logic [IDX_W-1:0]  rls_idx [RLS_W];

   always_comb begin
      occ = (tail >= head) ? tail - head : ptr_t'({1'b0, tail} + TWO_D - {1'b0, head});
   end

   // Allocation lanes are compacted: the k-th requesting lane takes the k-th free tag.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      n_req        = '0;
      alloc_preg_o = '0;
      for (int k = 0; k < ALLOC_W; k++) begin
         if (alloc_req_i[k]) begin
            alloc_preg_o[k*PREG_W +: PREG_W] = fl_mem[ptr_idx(ptr_add(head, n_req))];
            n_req = n_req + ptr_t'(1);
         end
      end
   end

   always_comb begin
      rls_we  = '0;
      rls_ovf = 1'b0;
      n_rls   = '0;
      room    = DEPTH_P - occ;
      for (int j = 0; j < RLS_W; j++) begin
         rls_idx[j] = ptr_idx(ptr_add(tail, n_rls));
         if (rls_vld_i[j]) begin
            if (n_rls < room) begin
               rls_we[j] = 1'b1;
               n_rls     = n_rls + ptr_t'(1);
            end else begin
               rls_ovf = 1'b1;
            end
         end
      end
   end

   always_comb begin
      cmt      = ptr_t'(commit_cnt_i);
      gnt      = reset_n && (n_req != '0) && (n_req <= occ) && !stall_i && !rec_i && !flush_i;
      head_gnt = gnt ? ptr_add(head, n_req) : head;
      if (flush_i)    head_nxt = ptr_add(arch_head, cmt);
      else if (rec_i) head_nxt = ckpt[rec_id_i];
      else            head_nxt = head_gnt;
   end

   assign alloc_gnt_o   = gnt;
   assign alloc_stall_o = n_req > occ;
   assign free_cnt_o    = CNT_W'(occ);
   assign err_ovf_o     = err_ovf;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the queue must come out of reset holding tags NUM_AREG.., so this array is reset.
         for (int i = 0; i < DEPTH; i++) fl_mem[i] <= PREG_W'(NUM_AREG + i);
      end else begin
         for (int j = 0; j < RLS_W; j++) begin
            if (rls_we[j]) fl_mem[rls_idx[j]] <= rls_preg_i[j*PREG_W +: PREG_W];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
         head      <= '0;
         tail      <= DEPTH_P;
         arch_head <= '0;
         err_ovf   <= 1'b0;
         for (int c = 0; c < NCKPT; c++) ckpt[c] <= '0;
      end else begin
         head      <= head_nxt;
         tail      <= ptr_add(tail, n_rls);
         arch_head <= ptr_add(arch_head, cmt);
         err_ovf   <= err_ovf | rls_ovf;
         if (ckpt_we_i && !rec_i && !flush_i) ckpt[ckpt_id_i] <= head_gnt;
      end
   end

endmodule

// File: tb/tb_free_list_ckpt.sv
// Bench for free_list_ckpt: directed scenarios plus randomized traffic checked against
// a sequence-number model of the free list (unbounded head/tail counters, tag per sequence).
module tb_free_list_ckpt;
   localparam int PREG_W   = 7;
   localparam int NUM_PREG = 80;
   localparam int NUM_AREG = 32;
   localparam int ALLOC_W  = 4;
   localparam int RLS_W    = 8;
   localparam int NCKPT    = 8;
   localparam int DEPTH    = NUM_PREG - NUM_AREG;

   logic                      clock = 1'b0;
   logic                      reset_n = 1'b0;
   logic [ALLOC_W-1:0]        alloc_req;
   logic                      stall;
   logic                      alloc_gnt;
   logic [ALLOC_W*PREG_W-1:0] alloc_preg;
   logic                      alloc_stall;
   logic [RLS_W-1:0]          rls_vld;
   logic [RLS_W*PREG_W-1:0]   rls_preg;
   logic [3:0]                commit_cnt;
   logic                      ckpt_we;
   logic [2:0]                ckpt_id;
   logic                      rec;
   logic [2:0]                rec_id;
   logic                      flush;
   logic [5:0]                free_cnt;
   logic                      err_ovf;

   always #5 clock = ~clock;

   free_list_ckpt dut (
      .clock(clock), .reset_n(reset_n),
      .alloc_req_i(alloc_req), .stall_i(stall),
      .alloc_gnt_o(alloc_gnt), .alloc_preg_o(alloc_preg), .alloc_stall_o(alloc_stall),
      .rls_vld_i(rls_vld), .rls_preg_i(rls_preg), .commit_cnt_i(commit_cnt),
      .ckpt_we_i(ckpt_we), .ckpt_id_i(ckpt_id), .rec_i(rec), .rec_id_i(rec_id),
      .flush_i(flush), .free_cnt_o(free_cnt), .err_ovf_o(err_ovf)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: tags indexed by absolute sequence number, pointers never wrap.
   int  m_head, m_tail, m_arch;
   int  m_ck [NCKPT];
   int  m_tag [int];
   bit  m_ovf;
   bit  e_gnt, e_stall;
   int  e_free;
   logic [ALLOC_W*PREG_W-1:0] e_preg, e_mask;

   task automatic model_reset();
      m_tag.delete();
      for (int i = 0; i < DEPTH; i++) m_tag[i] = NUM_AREG + i;
      m_head = 0; m_tail = DEPTH; m_arch = 0; m_ovf = 1'b0;
      for (int c = 0; c < NCKPT; c++) m_ck[c] = 0;
   endtask

   function automatic void model_eval();
      int nreq, idx;
      idx     = 0;
      e_free  = m_tail - m_head;
      nreq    = $countones(alloc_req);
      e_gnt   = nreq != 0 && nreq <= e_free && !stall && !rec && !flush;
      e_stall = nreq > e_free;
      e_preg  = '0;
      e_mask  = '0;
      for (int k = 0; k < ALLOC_W; k++) begin
         if (alloc_req[k]) begin
            if (m_head + idx < m_tail) begin
               e_preg[k*PREG_W +: PREG_W] = 7'(m_tag[m_head + idx]);
               e_mask[k*PREG_W +: PREG_W] = '1;
            end
            idx++;
         end else begin
            e_mask[k*PREG_W +: PREG_W] = '1;
         end
      end
   endfunction

   task automatic tick();
      int room, nacc, nh;
      model_eval();
      room = DEPTH - e_free;
      nacc = 0;
      for (int j = 0; j < RLS_W; j++) begin
         if (rls_vld[j]) begin
            if (nacc < room) begin
               m_tag[m_tail + nacc] = int'(rls_preg[j*PREG_W +: PREG_W]);
               nacc++;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      nh = e_gnt ? m_head + $countones(alloc_req) : m_head;
      if (ckpt_we && !rec && !flush) m_ck[ckpt_id] = nh;
      if (flush)    nh = m_arch + int'(commit_cnt);
      else if (rec) nh = m_ck[rec_id];
      m_arch = m_arch + int'(commit_cnt);
      m_tail = m_tail + nacc;
      m_head = nh;
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      alloc_req = '0; stall = 1'b0; rls_vld = '0; rls_preg = '0; commit_cnt = '0;
      ckpt_we = 1'b0; ckpt_id = '0; rec = 1'b0; rec_id = '0; flush = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      model_reset();
   endtask

   task automatic test_reset();
      idle();
      alloc_req = 4'b1111;
      reset_n   = 1'b0;
      @(negedge clock);
      n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt got=%0b exp=0", alloc_gnt); end
      n_checks++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL rst_free got=%0d exp=48", free_cnt); end
      n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%0b exp=0", err_ovf); end
      alloc_req = '0;
      reset_n   = 1'b1;
      @(posedge clock);
      #1;
      model_reset();
   endtask

   task automatic test_alloc_basic();
      alloc_req = 4'b1011;
      @(negedge clock);
      n_checks++; if (alloc_gnt !== 1'b1) begin n_fail++; $display("FAIL basic_gnt got=%0b exp=1", alloc_gnt); end
      n_checks++; if (alloc_preg !== {7'd34, 7'd0, 7'd33, 7'd32})
         begin n_fail++; $display("FAIL basic_tags got=%h exp=%h", alloc_preg, {7'd34, 7'd0, 7'd33, 7'd32}); end
      n_checks++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL basic_free0 got=%0d exp=48", free_cnt); end
      tick();
      alloc_req = '0;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd45) begin n_fail++; $display("FAIL basic_free1 got=%0d exp=45", free_cnt); end
      tick();
   endtask

   task automatic test_stall_release();
      int n;
      while (m_tail - m_head > 2) begin
         n = (m_tail - m_head - 2 > 4) ? 4 : m_tail - m_head - 2;
         alloc_req = 4'((1 << n) - 1);
         tick();
      end
      alloc_req = 4'b0111;
      rls_vld   = 8'b0000_0011;
      rls_preg  = '0;
      rls_preg[6:0]  = 7'd100;
      rls_preg[13:7] = 7'd101;
      @(negedge clock);
      n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL short_gnt got=%0b exp=0", alloc_gnt); end
      n_checks++; if (alloc_stall !== 1'b1) begin n_fail++; $display("FAIL short_stall got=%0b exp=1", alloc_stall); end
      n_checks++; if (free_cnt !== 6'd2) begin n_fail++; $display("FAIL short_free got=%0d exp=2", free_cnt); end
      tick();
      rls_vld = '0;
      @(negedge clock);
      n_checks++; if (alloc_gnt !== 1'b1) begin n_fail++; $display("FAIL refill_gnt got=%0b exp=1", alloc_gnt); end
      n_checks++; if (free_cnt !== 6'd4) begin n_fail++; $display("FAIL refill_free got=%0d exp=4", free_cnt); end
      n_checks++; if (alloc_preg !== {7'd0, 7'd100, 7'd79, 7'd78})
         begin n_fail++; $display("FAIL refill_tags got=%h exp=%h", alloc_preg, {7'd0, 7'd100, 7'd79, 7'd78}); end
      tick();
      alloc_req = '0;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd1) begin n_fail++; $display("FAIL refill_free1 got=%0d exp=1", free_cnt); end
      tick();
   endtask

   task automatic test_ckpt_recover();
      do_reset();
      alloc_req = 4'b0011; ckpt_we = 1'b1; ckpt_id = 3'd3;
      @(negedge clock);
      n_checks++; if (alloc_preg !== {7'd0, 7'd0, 7'd33, 7'd32})
         begin n_fail++; $display("FAIL ck_first got=%h exp=%h", alloc_preg, {7'd0, 7'd0, 7'd33, 7'd32}); end
      tick();
      ckpt_we = 1'b0; alloc_req = 4'b1111;
      tick();
      // Recover slot 3 while also trying to save slot 3: the save must be dropped.
      rec = 1'b1; rec_id = 3'd3; ckpt_we = 1'b1; ckpt_id = 3'd3;
      rls_vld = 8'b1; rls_preg = '0; rls_preg[6:0] = 7'd90;
      @(negedge clock);
      n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL ck_rec_gnt got=%0b exp=0", alloc_gnt); end
      tick();
      idle();
      alloc_req = 4'b0001;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd47) begin n_fail++; $display("FAIL ck_free got=%0d exp=47", free_cnt); end
      n_checks++; if (alloc_preg[6:0] !== 7'd34) begin n_fail++; $display("FAIL ck_tag got=%0d exp=34", alloc_preg[6:0]); end
      tick();
      alloc_req = '0; rec = 1'b1; rec_id = 3'd3;
      tick();
      rec = 1'b0; alloc_req = 4'b0001;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd47) begin n_fail++; $display("FAIL ck_again_free got=%0d exp=47", free_cnt); end
      n_checks++; if (alloc_preg[6:0] !== 7'd34) begin n_fail++; $display("FAIL ck_again_tag got=%0d exp=34", alloc_preg[6:0]); end
      tick();
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      alloc_req = 4'b1111; tick();
      commit_cnt = 4'd5;  tick();
      commit_cnt = 4'd0; alloc_req = 4'b0011; tick();
      flush = 1'b1; alloc_req = 4'b1111;
      @(negedge clock);
      n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL fl_gnt got=%0b exp=0", alloc_gnt); end
      n_checks++; if (free_cnt !== 6'd38) begin n_fail++; $display("FAIL fl_free0 got=%0d exp=38", free_cnt); end
      tick();
      flush = 1'b0; alloc_req = 4'b0001;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd43) begin n_fail++; $display("FAIL fl_free1 got=%0d exp=43", free_cnt); end
      n_checks++; if (alloc_preg[6:0] !== 7'd37) begin n_fail++; $display("FAIL fl_tag got=%0d exp=37", alloc_preg[6:0]); end
      tick();
      // Flush with a same-cycle commit of 2 and a release: head lands on arch_head + 2.
      alloc_req = '0; flush = 1'b1; commit_cnt = 4'd2;
      rls_vld = 8'b1; rls_preg = '0; rls_preg[6:0] = 7'd99;
      tick();
      idle();
      alloc_req = 4'b0001;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd42) begin n_fail++; $display("FAIL fl2_free got=%0d exp=42", free_cnt); end
      n_checks++; if (alloc_preg[6:0] !== 7'd39) begin n_fail++; $display("FAIL fl2_tag got=%0d exp=39", alloc_preg[6:0]); end
      tick();
      idle();
   endtask

   task automatic test_overflow();
      do_reset();
      alloc_req = 4'b1111; tick();
      alloc_req = '0; rls_vld = 8'hFF;
      for (int j = 0; j < RLS_W; j++) rls_preg[j*PREG_W +: PREG_W] = 7'(16 + j);
      @(negedge clock);
      n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_pre got=%0b exp=0", err_ovf); end
      tick();
      rls_vld = '0;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL ovf_free got=%0d exp=48", free_cnt); end
      n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got=%0b exp=1", err_ovf); end
      alloc_req = 4'b1111;
      for (int c = 0; c < 11; c++) tick();
      @(negedge clock);
      n_checks++; if (alloc_preg !== {7'd19, 7'd18, 7'd17, 7'd16})
         begin n_fail++; $display("FAIL ovf_tags got=%h exp=%h", alloc_preg, {7'd19, 7'd18, 7'd17, 7'd16}); end
      n_checks++; if (err_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got=%0b exp=1", err_ovf); end
      tick();
      alloc_req = 4'b0001;
      @(negedge clock);
      n_checks++; if (free_cnt !== 6'd0) begin n_fail++; $display("FAIL ovf_empty got=%0d exp=0", free_cnt); end
      n_checks++; if (alloc_stall !== 1'b1) begin n_fail++; $display("FAIL ovf_stall got=%0b exp=1", alloc_stall); end
      tick();
      idle();
   endtask

   task automatic test_random();
      int maxc, nv, room, nacc, tn, r, id;
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         idle();
         alloc_req = 4'($urandom_range(0, 15));
         stall     = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 2) == 0) rls_vld = 8'($urandom) & 8'($urandom);
         for (int j = 0; j < RLS_W; j++) rls_preg[j*PREG_W +: PREG_W] = 7'($urandom);
         maxc = m_head - m_arch;
         if (maxc > 8) maxc = 8;
         commit_cnt = 4'($urandom_range(0, maxc));
         ckpt_we = ($urandom_range(0, 3) == 0);
         ckpt_id = 3'($urandom);
         nv   = $countones(rls_vld);
         room = DEPTH - (m_tail - m_head);
         nacc = (nv < room) ? nv : room;
         tn   = m_tail + nacc;
         r    = $urandom_range(0, 19);
         id   = $urandom_range(0, NCKPT - 1);
         if (r == 0 && tn - (m_arch + int'(commit_cnt)) <= DEPTH) begin
            flush = 1'b1;
         end else if (r <= 2 && m_ck[id] >= m_arch + int'(commit_cnt) && m_ck[id] <= tn
                      && tn - m_ck[id] <= DEPTH) begin
            rec    = 1'b1;
            rec_id = 3'(id);
         end
         @(negedge clock);
         model_eval();
         n_checks++; if (alloc_gnt !== e_gnt)
            begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%0b exp=%0b", cyc, alloc_gnt, e_gnt); end
         n_checks++; if (alloc_stall !== e_stall)
            begin n_fail++; $display("FAIL rnd_stall cyc=%0d got=%0b exp=%0b", cyc, alloc_stall, e_stall); end
         n_checks++; if (int'(free_cnt) !== e_free)
            begin n_fail++; $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", cyc, free_cnt, e_free); end
         n_checks++; if ((alloc_preg & e_mask) !== e_preg)
            begin n_fail++; $display("FAIL rnd_tags cyc=%0d got=%h exp=%h", cyc, alloc_preg & e_mask, e_preg); end
         n_checks++; if (err_ovf !== m_ovf)
            begin n_fail++; $display("FAIL rnd_err cyc=%0d got=%0b exp=%0b", cyc, err_ovf, m_ovf); end
         tick();
      end
      idle();
   endtask

   task automatic test_reset_midop();
      alloc_req = 4'b1111;
      tick();
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      #1;
      n_checks++; if (free_cnt !== 6'd48) begin n_fail++; $display("FAIL mid_free got=%0d exp=48", free_cnt); end
      n_checks++; if (alloc_gnt !== 1'b0) begin n_fail++; $display("FAIL mid_gnt got=%0b exp=0", alloc_gnt); end
      n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("FAIL mid_err got=%0b exp=0", err_ovf); end
      @(negedge clock);
      reset_n = 1'b1;
      idle();
      @(posedge clock);
      #1;
      model_reset();
      alloc_req = 4'b1011;
      @(negedge clock);
      n_checks++; if (alloc_preg !== {7'd34, 7'd0, 7'd33, 7'd32})
         begin n_fail++; $display("FAIL mid_tags got=%h exp=%h", alloc_preg, {7'd34, 7'd0, 7'd33, 7'd32}); end
      tick();
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_alloc_basic();
      test_stall_release();
      test_ckpt_recover();
      test_flush();
      test_overflow();
      test_random();
      test_reset_midop();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
